// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU ops, states, mux selects.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;
  localparam logic [5:0] ANDN_FUNCT_DEFAULT = 6'h2c;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b11000;
  localparam logic [4:0] ALU_SLL  = 5'b11001;
  localparam logic [4:0] ALU_ANDN = 5'b11010;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RS = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXE_R,
    S_WB_R, S_EXE_I, S_WB_I, S_BRANCH, S_JUMP, S_JR
  } state_t;

  // Which rule the ALU op follows in the current state.
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_t;

  function automatic logic is_shift(input logic [5:0] f);
    return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
  endfunction

endpackage

// File: rtl/alu_conf_encoder.sv
// Combinational ALU op/signedness selection from state class, opcode and funct.
// Zero latency; no flow control.
module alu_conf_encoder
  import ctrl_pkg::*;
#(
  parameter logic [5:0] ANDN_FUNCT = ANDN_FUNCT_DEFAULT
) (
  input  alu_cls_t   cls,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output logic [4:0] alu_conf,
  output logic       sign
);

  always_comb begin
    alu_conf = ALU_ADD;
    sign     = 1'b0;
    case (cls)
      CLS_SUB: alu_conf = ALU_SUB;
      CLS_R: begin
        case (funct)
          F_ADD, F_ADDU: alu_conf = ALU_ADD;
          F_SUB, F_SUBU: alu_conf = ALU_SUB;
          F_AND:         alu_conf = ALU_AND;
          F_OR:          alu_conf = ALU_OR;
          F_XOR:         alu_conf = ALU_XOR;
          F_NOR:         alu_conf = ALU_NOR;
          F_SLT:         begin alu_conf = ALU_SLT; sign = 1'b1; end
          F_SLTU:        alu_conf = ALU_SLT;
          F_SLL:         alu_conf = ALU_SLL;
          F_SRL:         alu_conf = ALU_SRL;
          F_SRA:         alu_conf = ALU_SRA;
          ANDN_FUNCT:    alu_conf = ALU_ANDN;
          default:       alu_conf = ALU_ADD;
        endcase
      end
      CLS_I: begin
        case (op_code)
          OP_ANDI:  alu_conf = ALU_AND;
          OP_ORI:   alu_conf = ALU_OR;
          OP_SLTI:  begin alu_conf = ALU_SLT; sign = 1'b1; end
          OP_SLTIU: alu_conf = ALU_SLT;
          default:  alu_conf = ALU_ADD;
        endcase
      end
      default: alu_conf = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multi-cycle MIPS datapath: IF/ID/EX/MEM/WB sequencing, strobes, mux selects, ALU op.
// Moore outputs, 2-5 cycles per instruction; no backpressure, reset forces all outputs idle at once.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [5:0] ANDN_FUNCT = ANDN_FUNCT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [4:0] ALUConf,
  output logic       Sign
);

  state_t   state, next_state;
  alu_cls_t cls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: begin
        case (OpCode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = (Funct == F_JR || Funct == F_JALR) ? S_JR : S_EXE_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_SLTI, OP_SLTIU, OP_LUI: next_state = S_EXE_I;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J, OP_JAL: next_state = S_JUMP;
          default:      next_state = S_IF;
        endcase
      end
      S_MEMADR: next_state = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXE_R:  next_state = S_WB_R;
      S_EXE_I:  next_state = S_WB_I;
      default:  next_state = S_IF;
    endcase
  end

  // Reset gating keeps the ALU on ADD while held, even though the state already reads S_IF.
  always_comb begin
    cls = CLS_ADD;
    if (!reset) begin
      case (state)
        S_BRANCH: cls = CLS_SUB;
        S_EXE_R:  cls = CLS_R;
        S_EXE_I:  cls = CLS_I;
        default:  cls = CLS_ADD;
      endcase
    end
  end

  alu_conf_encoder #(.ANDN_FUNCT(ANDN_FUNCT)) u_alu_conf (
    .cls      (cls),
    .op_code  (OpCode),
    .funct    (Funct),
    .alu_conf (ALUConf),
    .sign     (Sign)
  );

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALU;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    PCSource    = PCSRC_ALU;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          PCWrite = 1'b1; MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = SRCB_FOUR;
        end
        S_ID: begin
          ALUSrcB = SRCB_IMM_SH; ExtOp = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS; ALUSrcB = SRCB_IMM; ExtOp = 1'b1;
        end
        S_MEMRD: begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEMWB: begin RegWrite = 1'b1; MemtoReg = M2R_MDR; end
        S_MEMWR: begin MemWrite = 1'b1; IorD = 1'b1; end
        S_EXE_R: ALUSrcA = is_shift(Funct) ? SRCA_SHAMT : SRCA_RS;
        S_WB_R:  begin RegWrite = 1'b1; RegDst = DST_RD; end
        S_EXE_I: begin
          ALUSrcA = SRCA_RS; ALUSrcB = SRCB_IMM;
          ExtOp   = !(OpCode == OP_ANDI || OpCode == OP_ORI);
          LuOp    = (OpCode == OP_LUI);
        end
        S_WB_I: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = SRCA_RS; PCWriteCond = 1'b1; PCSource = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite = 1'b1; PCSource = PCSRC_JUMP;
          if (OpCode == OP_JAL) begin
            RegWrite = 1'b1; RegDst = DST_RA; MemtoReg = M2R_PC;
          end
        end
        S_JR: begin
          PCWrite = 1'b1; PCSource = PCSRC_RS;
          if (Funct == F_JALR) begin
            RegWrite = 1'b1; RegDst = DST_RD; MemtoReg = M2R_PC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
